// File: rtl/sonic_pkg.sv
// -----------------------------------------------------------------------------
// sonic_pkg
// Shared definitions for the HC-SR04 ultrasonic ranger.
//   - state_t       : ranging FSM state encoding
//   - DEF_*         : default timing constants for a 50 MHz system clock
//   - FILTER_DEPTH  : consecutive equal samples the optional echo glitch
//                     filter needs before its output changes
//   - CNT_W / SUB_W : counter widths
// -----------------------------------------------------------------------------
package sonic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        ECHO,
        HOLDOFF
    } state_t;

    // Defaults at 50 MHz.
    localparam int DEF_TRIG_CYCLES    = 500;        // 10 us trig pulse
    localparam int DEF_CYCLES_PER_MM  = 291;        // 2 * 50e6 / 343000
    localparam int DEF_TIMEOUT_CYCLES = 2_000_000;  // 40 ms echo limit
    localparam int DEF_HOLDOFF_CYCLES = 3_000_000;  // 60 ms ping spacing
    localparam int DEF_MAX_MM         = 4000;       // saturation / no echo

    localparam int FILTER_DEPTH = 4;

    localparam int CNT_W = 22;  // trig width, timeout and holdoff counting
    localparam int SUB_W = 9;   // clocks-within-one-millimetre counter

endpackage

// File: rtl/sonic_echo_sync.sv
// -----------------------------------------------------------------------------
// sonic_echo_sync
// Brings the asynchronous sensor echo pin into the clock domain and produces
// a clean level plus one-cycle edge strobes.
//
// Optional feature macro: SONIC_ECHO_FILTER_EN
//   defined   : a glitch filter follows the 2-flop synchroniser; the output
//               level changes only after FILTER_DEPTH consecutive equal
//               samples, so shorter pulses are dropped.
//   undefined : the output follows the synchronised echo directly.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   echo_async in   raw echo pin
//   level      out  filtered / synchronised echo level
//   rise       out  one-cycle strobe: level is going high at this edge
//   fall       out  one-cycle strobe: level is going low at this edge
// -----------------------------------------------------------------------------
module sonic_echo_sync
    import sonic_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic echo_async,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic level_q;
    logic change;

    // NOTE: every clocked register below uses non-blocking assignment so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= echo_async;
            sync2 <= sync1;
        end
    end

`ifdef SONIC_ECHO_FILTER_EN
    // Count how many consecutive samples have disagreed with the current
    // output; the change is accepted on the FILTER_DEPTH-th one.
    localparam logic [1:0] RUN_LAST = 2'(FILTER_DEPTH - 1);

    logic [1:0] run_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt <= '0;
        end else if (sync2 != level_q && run_cnt != RUN_LAST) begin
            run_cnt <= run_cnt + 2'd1;
        end else begin
            run_cnt <= '0;
        end
    end

    assign change = (sync2 != level_q) && (run_cnt == RUN_LAST);
`else
    assign change = (sync2 != level_q);
`endif

    // The strobes are decoded from the update condition rather than from a
    // delayed copy of the level, so the consumer sees the edge in the same
    // cycle the level register takes it (no extra clock of latency).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else if (change) begin
            level_q <= sync2;
        end
    end

    assign level = level_q;
    assign rise  = change &  sync2;
    assign fall  = change & ~sync2;

endmodule

// File: rtl/sonic_ranger.sv
// -----------------------------------------------------------------------------
// sonic_ranger
// Responder side of the ultrasonic ranging handshake. On a level request it
// fires a TRIG_CYCLES-wide trig pulse at the HC-SR04, acknowledges with
// triggerSuc, times the echo pulse and converts it to millimetres by
// repeated counting, then reports the result with a one-cycle valid pulse.
// A holdoff period enforces the sensor's minimum ping spacing.
//
// Optional feature macro: SONIC_ECHO_FILTER_EN (echo glitch filter inside
// sonic_echo_sync; raises the echo-fall to valid latency from 3 to 6 clocks).
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   trigger     in   level measurement request (sampled only in IDLE)
//   triggerSuc  out  one-cycle pulse: trig pulse delivered
//   valid       out  one-cycle pulse: distance updated
//   distance    out  [31:0] last range in mm, held between valid pulses
//   sonic_trig  out  sensor trig pin
//   sonic_echo  in   sensor echo pin (asynchronous)
// -----------------------------------------------------------------------------
module sonic_ranger
    import sonic_pkg::*;
#(
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int CYCLES_PER_MM  = DEF_CYCLES_PER_MM,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int MAX_MM         = DEF_MAX_MM
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger,
    output logic        triggerSuc,
    output logic        valid,
    output logic [31:0] distance,
    output logic        sonic_trig,
    input  logic        sonic_echo
);

    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [SUB_W-1:0] SUB_LAST     = SUB_W'(CYCLES_PER_MM - 1);
    localparam logic [31:0]      MAX_D        = 32'(MAX_MM);

    state_t state, state_nx;

    // One phase counter serves the trig width, the timeout (which runs
    // uninterrupted from WAIT_ECHO entry through ECHO) and the holdoff.
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [SUB_W-1:0] sub, sub_nx, sub_base;
    logic [31:0]      acc, acc_nx, acc_base;
    logic             tick;

    logic             trig_nx, suc_nx, valid_nx;
    logic [31:0]      dist_nx;

    logic echo_level, echo_rise, echo_fall;

    sonic_echo_sync u_echo_sync (
        .clk        (clk),
        .rst        (rst),
        .echo_async (sonic_echo),
        .level      (echo_level),
        .rise       (echo_rise),
        .fall       (echo_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sub        <= '0;
            acc        <= '0;
            sonic_trig <= 1'b0;
            triggerSuc <= 1'b0;
            valid      <= 1'b0;
            distance   <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            sub        <= sub_nx;
            acc        <= acc_nx;
            sonic_trig <= trig_nx;
            triggerSuc <= suc_nx;
            valid      <= valid_nx;
            distance   <= dist_nx;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        sub_nx   = sub;
        acc_nx   = acc;
        sub_base = sub;
        acc_base = acc;
        tick     = 1'b0;
        trig_nx  = 1'b0;
        suc_nx   = 1'b0;
        valid_nx = 1'b0;
        dist_nx  = distance;

        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (trigger) begin
                    state_nx = TRIG;
                    trig_nx  = 1'b1;
                end
            end

            TRIG: begin
                trig_nx = 1'b1;
                if (cnt == TRIG_LAST) begin
                    state_nx = WAIT_ECHO;
                    trig_nx  = 1'b0;
                    suc_nx   = 1'b1;
                    cnt_nx   = '0;
                end
            end

            WAIT_ECHO: begin
                if (cnt == TIMEOUT_LAST) begin
                    state_nx = HOLDOFF;
                    dist_nx  = MAX_D;
                    valid_nx = 1'b1;
                    cnt_nx   = {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (echo_rise) begin
                    // The rise edge is itself the first echo-high clock.
                    state_nx = ECHO;
                    sub_base = '0;
                    acc_base = '0;
                    tick     = 1'b1;
                end
            end

            ECHO: begin
                // Echo fall takes priority over a coincident timeout.
                if (echo_fall) begin
                    state_nx = HOLDOFF;
                    dist_nx  = acc;
                    valid_nx = 1'b1;
                    cnt_nx   = {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nx = HOLDOFF;
                    dist_nx  = MAX_D;
                    valid_nx = 1'b1;
                    cnt_nx   = {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (echo_level) begin
                    tick = 1'b1;
                end
            end

            HOLDOFF: begin
                // The result cycle counts as the first holdoff clock, so the
                // next trig can start exactly HOLDOFF_CYCLES after valid.
                if (cnt >= HOLD_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end

            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase

        // Millimetre conversion without a divider: every CYCLES_PER_MM
        // echo-high clocks bump the accumulator, which saturates at MAX_MM.
        if (tick) begin
            if (sub_base == SUB_LAST) begin
                sub_nx = '0;
                acc_nx = (acc_base >= MAX_D) ? MAX_D : acc_base + 32'd1;
            end else begin
                sub_nx = sub_base + 1'b1;
                acc_nx = acc_base;
            end
        end
    end

endmodule
